rf_port_arbiter: RTL

- Shares the single write/read port pair of the 7 x 64-bit register file between two requesters.
- Master 0 is the bus-slave side; master 1 is the factorial core engine.
- Performs round-robin arbitration with one access per cycle, registers read data, and flags out-of-range addresses.
- Sits between the core's bus-slave and FSM logic and the register file instance.

---
 rtl/rf_arb_pkg.sv | 20 ++
 rtl/rf_port_arbiter_rr_pick2.sv | 20 ++
 rtl/rf_port_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file port arbiter.
//   NUM_REGS_DEF / ADDR_W_DEF / DATA_W_DEF : default geometry of the 7 x 64-bit file
//   M0 / M1                                : master indices (bus slave, factorial core)
//   owner_t                                : port ownership state for the optional lock feature
package rf_arb_pkg;

  localparam int NUM_REGS_DEF = 7;
  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 64;

  localparam int M0 = 0;
  localparam int M1 = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

endpackage

// File: rtl/rf_port_arbiter_rr_pick2.sv
// Two-input round-robin picker.
//   req[1:0]  : active requests (already masked by reset / ownership)
//   last_gnt  : index of the master granted most recently
//   gnt[1:0]  : one-hot (or zero) grant, combinational
module rr_pick2
  import rf_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // On contention the master that was not granted last time wins.
  always_comb begin
    gnt      = 2'b00;
    gnt[M0]  = req[M0] & (~req[M1] | last_gnt);
    gnt[M1]  = req[M1] & (~req[M0] | ~last_gnt);
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares the single write/read port pair of the register file between the
// bus-slave side (master 0) and the factorial core engine (master 1).
// One access per cycle, round-robin on contention, registered read data.
//
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   m0_lock, m1_lock         : ownership request (only with RF_ARB_LOCK_EN)
//   mX_req/wr/addr/wdata     : access request of master X, held until granted
//   mX_gnt                   : access performed this cycle (combinational)
//   mX_rvalid/rdata/err      : read result / out-of-range flag, cycle after grant
//   rf_we/waddr/wdata/raddr  : register file drive
//   rf_rdata                 : register file combinational read data
//
// Build option: define RF_ARB_LOCK_EN to add the lock inputs and the
// ownership FSM that lets one master hold the port for read-modify-write.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
`ifdef RF_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata
);

  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic [1:0]        req_p0;
  logic [1:0]        gnt_p0;
  logic              any_gnt_p0;
  logic              sel_p0;
  logic              wr_p0;
  logic              in_range_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] rdata_p0;
  logic              last_gnt;

  logic [1:0]        vld_p1;
  logic [1:0]        err_p1;
  logic [DATA_W-1:0] rdata0_p1;
  logic [DATA_W-1:0] rdata1_p1;

`ifdef RF_ARB_LOCK_EN
  owner_t owner;
`endif

  // ---- stage p0: request masking, grant and register file drive ----
  // Requests are ignored during reset so no access (and no rf_we) happens
  // in a reset cycle.
  always_comb begin
    req_p0 = {m1_req, m0_req} & {2{~reset}};
`ifdef RF_ARB_LOCK_EN
    if (owner == OWN0) req_p0[M1] = 1'b0;
    if (owner == OWN1) req_p0[M0] = 1'b0;
`endif
  end

  rr_pick2 u_pick (
    .req      (req_p0),
    .last_gnt (last_gnt),
    .gnt      (gnt_p0)
  );

  always_comb begin
    any_gnt_p0 = |gnt_p0;
    sel_p0     = gnt_p0[M1];
    wr_p0      = 1'b0;
    addr_p0    = '0;
    wdata_p0   = '0;
    if (any_gnt_p0) begin
      wr_p0    = sel_p0 ? m1_wr    : m0_wr;
      addr_p0  = sel_p0 ? m1_addr  : m0_addr;
      wdata_p0 = sel_p0 ? m1_wdata : m0_wdata;
    end
    in_range_p0 = (addr_p0 < NUM_REGS_A);
    // Out-of-range reads return zero rather than whatever the file drives.
    rdata_p0    = in_range_p0 ? rf_rdata : '0;
  end

  assign rf_we    = any_gnt_p0 & wr_p0 & in_range_p0;
  assign rf_waddr = addr_p0;
  assign rf_raddr = addr_p0;
  assign rf_wdata = wdata_p0;

  assign m0_gnt   = gnt_p0[M0];
  assign m1_gnt   = gnt_p0[M1];

  // ---- stage p1: registered read data, valid and error pulses ----
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt  <= 1'b1;
      vld_p1    <= 2'b00;
      err_p1    <= 2'b00;
      rdata0_p1 <= '0;
      rdata1_p1 <= '0;
    end else begin
      if (any_gnt_p0) last_gnt <= sel_p0;
      vld_p1 <= gnt_p0 & {2{~wr_p0}};
      err_p1 <= gnt_p0 & {2{~in_range_p0}};
      if (gnt_p0[M0] && !wr_p0) rdata0_p1 <= rdata_p0;
      if (gnt_p0[M1] && !wr_p0) rdata1_p1 <= rdata_p0;
    end
  end

  // A reset arriving in the cycle a pulse is due cancels that pulse.
  assign m0_rvalid = vld_p1[M0] & ~reset;
  assign m1_rvalid = vld_p1[M1] & ~reset;
  assign m0_err    = err_p1[M0] & ~reset;
  assign m1_err    = err_p1[M1] & ~reset;
  assign m0_rdata  = rdata0_p1;
  assign m1_rdata  = rdata1_p1;

`ifdef RF_ARB_LOCK_EN
  // Ownership: a granted access with lock=1 claims the port; the owner's
  // next granted access with lock=0 releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= IDLE;
    end else begin
      case (owner)
        IDLE: begin
          if (gnt_p0[M0] && m0_lock)      owner <= OWN0;
          else if (gnt_p0[M1] && m1_lock) owner <= OWN1;
        end
        OWN0:    if (gnt_p0[M0] && !m0_lock) owner <= IDLE;
        OWN1:    if (gnt_p0[M1] && !m1_lock) owner <= IDLE;
        default: owner <= IDLE;
      endcase
    end
  end
`endif

endmodule
